uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx_cfg.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and parity-mode encodings.
// uart_rx_cfg uses these today; a matching transmitter can reuse them.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so an idle-high line does not look like a start bit.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_l,
  input  logic d,
  output logic q
);

  logic d_p0;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      d_p0 <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      d_p0 <= d;
      q    <= d_p0;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits,
// held output word with ready handshake, framing/parity flags and sticky overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Rx_Active
);

  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_rx_cfg: CLKS_PER_BIT must be 4..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Even parity flags a set XOR; odd parity flags a clear one.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic s);
    logic x;
    x = (^d) ^ s;
    return (PARITY == PAR_ODD) ? ~x : x;
  endfunction

  state_t               state;
  state_t               next_state;
  logic                 rx;
  logic [CNT_W-1:0]     clk_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 frm_acc;
  logic                 bit_done;
  logic                 half_done;
  logic                 cnt_clr;
  logic                 bit_clr;
  logic                 bit_inc;
  logic                 shift_en;
  logic                 par_en;
  logic                 stop_en;
  logic                 err_clr;
  logic                 load;
  logic                 ovr_set;

  // Line synchroniser: everything downstream sees only rx.
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (i_Clock),
    .rst_l (i_Rst_L),
    .d     (i_Rx_Serial),
    .q     (rx)
  );

  assign bit_done  = (clk_cnt == CNT_LAST);
  assign half_done = (clk_cnt == CNT_HALF);

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (!rx) next_state = S_START;
      S_START:   if (half_done) next_state = rx ? S_IDLE : S_DATA;
      S_DATA:    if (bit_done && bit_cnt == DATA_LAST)
                   next_state = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY:  if (bit_done) next_state = S_STOP;
      S_STOP:    if (bit_done && bit_cnt == STOP_LAST) next_state = S_CLEANUP;
      S_CLEANUP: next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from the current state; bit_cnt restarts on every state change.
  always_comb begin
    o_Rx_Active = (state != S_IDLE);
    cnt_clr     = 1'b1;
    bit_clr     = (next_state != state);
    bit_inc     = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    err_clr     = 1'b0;
    load        = 1'b0;
    ovr_set     = 1'b0;
    case (state)
      S_START: begin
        cnt_clr = half_done;
        err_clr = 1'b1;
      end
      S_DATA: begin
        cnt_clr  = bit_done;
        shift_en = bit_done;
        bit_inc  = bit_done;
      end
      S_PARITY: begin
        cnt_clr = bit_done;
        par_en  = bit_done;
      end
      S_STOP: begin
        cnt_clr = bit_done;
        stop_en = bit_done;
        bit_inc = bit_done;
      end
      S_CLEANUP: begin
        load    = !o_Rx_DV || i_Rx_Ready;
        ovr_set = o_Rx_DV && !i_Rx_Ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (shift_en) shreg <= {rx, shreg[DATA_BITS-1:1]};
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      par_acc      <= 1'b0;
      frm_acc      <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Overrun    <= 1'b0;
    end else begin
      clk_cnt <= cnt_clr ? '0 : clk_cnt + 1'b1;
      if (bit_clr)      bit_cnt <= '0;
      else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;
      if (err_clr) begin
        par_acc <= 1'b0;
        frm_acc <= 1'b0;
      end
      if (par_en)         par_acc <= parity_bad(shreg, rx);
      if (stop_en && !rx) frm_acc <= 1'b1;
      // Output hand-off: a new load wins over a simultaneous ready clear.
      if (load) begin
        o_Rx_Byte    <= shreg;
        o_Parity_Err <= par_acc;
        o_Frame_Err  <= frm_acc;
      end
      if (load)            o_Rx_DV <= 1'b1;
      else if (i_Rx_Ready) o_Rx_DV <= 1'b0;
      if (ovr_set) o_Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four configurations driven by random and directed serial frames,
// each received word compared against expectations computed from the frame contents.
module tb_uart_rx_cfg;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rx, rdy, rstn, dv, pe, fe, ov, act;
  logic [7:0] by0, by1, by2;
  logic [4:0] by3;
  int total = 0;
  int bad   = 0;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d0 (
    .i_Clock(clk), .i_Rst_L(rstn[0]), .i_Rx_Serial(rx[0]), .i_Rx_Ready(rdy[0]),
    .o_Rx_DV(dv[0]), .o_Rx_Byte(by0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]),
    .o_Overrun(ov[0]), .o_Rx_Active(act[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) d1 (
    .i_Clock(clk), .i_Rst_L(rstn[1]), .i_Rx_Serial(rx[1]), .i_Rx_Ready(rdy[1]),
    .o_Rx_DV(dv[1]), .o_Rx_Byte(by1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]),
    .o_Overrun(ov[1]), .o_Rx_Active(act[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) d2 (
    .i_Clock(clk), .i_Rst_L(rstn[2]), .i_Rx_Serial(rx[2]), .i_Rx_Ready(rdy[2]),
    .o_Rx_DV(dv[2]), .o_Rx_Byte(by2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]),
    .o_Overrun(ov[2]), .o_Rx_Active(act[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) d3 (
    .i_Clock(clk), .i_Rst_L(rstn[3]), .i_Rx_Serial(rx[3]), .i_Rx_Ready(rdy[3]),
    .o_Rx_DV(dv[3]), .o_Rx_Byte(by3), .o_Parity_Err(pe[3]), .o_Frame_Err(fe[3]),
    .o_Overrun(ov[3]), .o_Rx_Active(act[3]));

  function automatic int nbits(input int d);
    return (d == 3) ? 5 : 8;
  endfunction

  function automatic int pmode(input int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : 0;
  endfunction

  function automatic int nstop(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  function automatic logic [8:0] mask(input int d);
    return 9'((1 << nbits(d)) - 1);
  endfunction

  function automatic logic [8:0] get_byte(input int d);
    case (d)
      0:       return {1'b0, by0};
      1:       return {1'b0, by1};
      2:       return {1'b0, by2};
      default: return {4'b0, by3};
    endcase
  endfunction

  // Parity bit a well-behaved transmitter would send for this data.
  function automatic logic good_parity(input int d, input logic [8:0] data);
    int ones;
    ones = $countones(data & mask(d)) % 2;
    return (pmode(d) == 1) ? (ones == 1) : (ones == 0);
  endfunction

  function automatic logic exp_perr(input int d, input logic [8:0] data, input logic pbit);
    return (pmode(d) != 0) && (pbit != good_parity(d, data));
  endfunction

  function automatic logic exp_ferr(input int d, input logic [1:0] stops);
    return (stops[0] == 1'b0) || (nstop(d) == 2 && stops[1] == 1'b0);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input int d, input logic v);
    rx[d] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input logic pbit,
                            input logic [1:0] stops);
    drive_bit(d, 1'b0);
    for (int i = 0; i < nbits(d); i++) drive_bit(d, data[i]);
    if (pmode(d) != 0) drive_bit(d, pbit);
    for (int i = 0; i < nstop(d); i++) drive_bit(d, stops[i]);
    rx[d] = 1'b1;
  endtask

  task automatic expect_word(input int d, input logic [8:0] eb, input logic ep,
                             input logic ef, input logic pulse);
    int n;
    n = 0;
    while (!dv[d] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!dv[d]) begin
      check_eq($sformatf("d%0d_dv_timeout", d), 32'(dv[d]), 32'd1);
      return;
    end
    check_eq($sformatf("d%0d_byte", d), 32'(get_byte(d)), 32'(eb & mask(d)));
    check_eq($sformatf("d%0d_parity_err", d), 32'(pe[d]), 32'(ep));
    check_eq($sformatf("d%0d_frame_err", d), 32'(fe[d]), 32'(ef));
    if (pulse) begin
      @(negedge clk);
      check_eq($sformatf("d%0d_dv_pulse", d), 32'(dv[d]), 32'd0);
    end
  endtask

  task automatic check_zero(input int d, input string tag);
    check_eq($sformatf("d%0d_%s_dv", d, tag), 32'(dv[d]), 32'd0);
    check_eq($sformatf("d%0d_%s_byte", d, tag), 32'(get_byte(d)), 32'd0);
    check_eq($sformatf("d%0d_%s_perr", d, tag), 32'(pe[d]), 32'd0);
    check_eq($sformatf("d%0d_%s_ferr", d, tag), 32'(fe[d]), 32'd0);
    check_eq($sformatf("d%0d_%s_ovr", d, tag), 32'(ov[d]), 32'd0);
    check_eq($sformatf("d%0d_%s_act", d, tag), 32'(act[d]), 32'd0);
  endtask

  task automatic rand_frames(input int d, input int n);
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stops;
    for (int k = 0; k < n; k++) begin
      data     = 9'($urandom) & mask(d);
      pbit     = good_parity(d, data) ^ ($urandom_range(0, 3) == 0);
      stops[0] = ($urandom_range(0, 3) != 0);
      stops[1] = ($urandom_range(0, 3) != 0);
      send_frame(d, data, pbit, stops);
      expect_word(d, data, exp_perr(d, data, pbit), exp_ferr(d, stops), 1'b1);
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got_dv;
    logic saw_act;
    rx   = '1;
    rdy  = '1;
    rstn = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) check_zero(d, "reset");
    rstn = '1;
    repeat (2) @(negedge clk);

    // Parity: 0x56 has an even number of ones, so parity bit 0 is right for even, wrong for odd.
    send_frame(1, 9'h56, 1'b0, 2'b11);
    expect_word(1, 9'h56, 1'b0, 1'b0, 1'b1);
    send_frame(2, 9'h56, 1'b0, 2'b11);
    expect_word(2, 9'h56, 1'b1, 1'b0, 1'b1);

    send_frame(0, 9'hAB, 1'b0, 2'b10);
    expect_word(0, 9'hAB, 1'b0, 1'b1, 1'b1);
    repeat (CPB) @(negedge clk);
    send_frame(0, 9'h3F, 1'b0, 2'b11);
    expect_word(0, 9'h3F, 1'b0, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);

    for (int d = 0; d < 4; d++) rand_frames(d, 6);

    // One-cycle low glitch must be rejected.
    got_dv  = 1'b0;
    saw_act = 1'b0;
    rx[0] = 1'b0;
    @(negedge clk);
    rx[0] = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dv[0])  got_dv  = 1'b1;
      if (act[0]) saw_act = 1'b1;
    end
    check_eq("glitch_dv", 32'(got_dv), 32'd0);
    check_eq("glitch_active_seen", 32'(saw_act), 32'd1);
    check_eq("glitch_back_idle", 32'(act[0]), 32'd0);

    // Reset in the middle of a 5-bit, 2-stop frame.
    send_frame(3, 9'h15, 1'b0, 2'b11);
    expect_word(3, 9'h15, 1'b0, 1'b0, 1'b1);
    repeat (CPB) @(negedge clk);
    drive_bit(3, 1'b0);
    drive_bit(3, 1'b1);
    drive_bit(3, 1'b0);
    check_eq("d3_mid_frame_active", 32'(act[3]), 32'd1);
    rstn[3] = 1'b0;
    rx[3]   = 1'b1;
    repeat (2) @(negedge clk);
    check_zero(3, "midreset");
    rstn[3] = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(3, 9'h0A, 1'b0, 2'b11);
    expect_word(3, 9'h0A, 1'b0, 1'b0, 1'b1);

    // Overrun: second frame arrives while the first is still held.
    rdy[0] = 1'b0;
    send_frame(0, 9'h11, 1'b0, 2'b11);
    send_frame(0, 9'h22, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    check_eq("ovr_dv_held", 32'(dv[0]), 32'd1);
    check_eq("ovr_byte_held", 32'(get_byte(0)), 32'h11);
    check_eq("ovr_flag", 32'(ov[0]), 32'd1);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check_eq("ovr_dv_cleared", 32'(dv[0]), 32'd0);
    check_eq("ovr_sticky", 32'(ov[0]), 32'd1);
    check_eq("ovr_byte_after", 32'(get_byte(0)), 32'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
